// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the packing UART receiver
// Purpose: parity mode enum, receiver FSM state enum, and beat width helpers.
// Ports: none (package).
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_RECOVER
  } rx_state_t;

  localparam int unsigned DEF_DATA_BITS = 8;
  localparam int unsigned DEF_LANES     = 4;
  localparam int unsigned BEAT_W        = DEF_LANES * DEF_DATA_BITS;

  // Beat width for a given lane count and character width.
  function automatic int unsigned beat_width(input int unsigned lanes,
                                             input int unsigned bits);
    return lanes * bits;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - show-ahead synchronous FIFO with registered head output
// Purpose: buffers completed beats; dout always holds the oldest entry.
// Ports:
//   aclk, areset      clock, synchronous active-high reset
//   push, din         write strobe and data (ignored when full unless popping)
//   pop               read strobe (ignored when empty)
//   dout              registered head entry
//   full, empty       occupancy flags
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
      // Keep the head register pointing at the oldest live entry.
      if (do_pop) begin
        if (count > ONE_CNT)  dout <= mem[rd_ptr + 1'b1];
        else if (do_push)     dout <= din;
      end else if (empty && do_push) begin
        dout <= din;
      end
    end
  end

endmodule

// File: rtl/axis_uart_rx_pkt.sv
// rtl/axis_uart_rx_pkt.sv - UART receiver packing characters into AXI-Stream beats
// Purpose: oversampled UART RX with runtime divisor, parity, 1/2 stop bits,
//   lane packing, idle-timeout flush and break detection, feeding a beat FIFO.
// Ports:
//   aclk, areset        clock, synchronous active-high reset
//   uart_rx             asynchronous serial input, idle high
//   baud_div            clocks per bit (>=4), latched at each start edge
//   m_axis_*            packed beat output (tdata/tkeep/tlast/tvalid/tready)
//   err_parity/frame/break  one-cycle error pulses, at most one per frame
//   overflow            one-cycle pulse when a beat is dropped on a full FIFO
module axis_uart_rx_pkt
  import uart_pkg::*;
#(
  parameter int unsigned  DATA_BITS   = 8,
  parameter parity_mode_t PARITY_MODE = PAR_EVEN,
  parameter int unsigned  STOP_BITS   = 1,
  parameter int unsigned  LANES       = 4,
  parameter int unsigned  FIFO_DEPTH  = 8,
  parameter int unsigned  IDLE_BITS   = 16
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         uart_rx,
  input  logic [15:0]                  baud_div,
  output logic [LANES*DATA_BITS-1:0]   m_axis_tdata,
  output logic [LANES-1:0]             m_axis_tkeep,
  output logic                         m_axis_tlast,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         err_parity,
  output logic                         err_frame,
  output logic                         err_break,
  output logic                         overflow
);

  localparam int unsigned BW = beat_width(LANES, DATA_BITS);
  localparam int unsigned FW = BW + LANES + 1;
  localparam int unsigned PW = $clog2(LANES + 1);
  localparam int unsigned CW = $clog2(DATA_BITS + 1);
  localparam int unsigned TW = $clog2(IDLE_BITS + 1) + 16;

  logic                 rx_meta, rxs, rxs_d;
  rx_state_t            state;
  logic [15:0]          div_q, bc, half;
  logic                 s0, s1, s2;
  logic [CW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit, par_err, stop_bad;
  logic [PW-1:0]        ptr;
  logic [BW-1:0]        lane_buf, lane_ins;
  logic [LANES-1:0]     part_keep;
  logic [TW-1:0]        idle_cnt, idle_lim;
  logic                 push_req;
  logic [FW-1:0]        push_data;
  logic [FW-1:0]        fifo_dout;
  logic                 fifo_full, fifo_empty, pop;
  logic                 bit_end, s2_now, maj, start_edge, stop_zero, is_break;

  assign half       = {1'b0, div_q[15:1]};
  assign bit_end    = (bc == div_q - 16'd1);
  // With div=4 the third sample lands on the decision cycle; use the live value.
  assign s2_now     = (bc == half + 16'd1) ? rxs : s2;
  assign maj        = (s0 & s1) | (s0 & s2_now) | (s1 & s2_now);
  assign start_edge = (state == ST_IDLE) && rxs_d && !rxs;
  assign stop_zero  = stop_bad | ~maj;
  assign is_break   = stop_zero && (shreg == '0) && !par_bit;
  assign idle_lim   = TW'(IDLE_BITS) * TW'(div_q);

  always_comb begin
    lane_ins = lane_buf;
    for (int k = 0; k < LANES; k++) begin
      if (ptr == PW'(k)) lane_ins[k*DATA_BITS +: DATA_BITS] = shreg;
    end
  end

  always_comb begin
    part_keep = '0;
    for (int k = 0; k < LANES; k++) part_keep[k] = (PW'(k) < ptr);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rx_meta    <= 1'b1;
      rxs        <= 1'b1;
      rxs_d      <= 1'b1;
      state      <= ST_IDLE;
      div_q      <= '0;
      bc         <= '0;
      s0         <= 1'b0;
      s1         <= 1'b0;
      s2         <= 1'b0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      par_err    <= 1'b0;
      stop_bad   <= 1'b0;
      ptr        <= '0;
      lane_buf   <= '0;
      idle_cnt   <= '0;
      push_req   <= 1'b0;
      push_data  <= '0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
      err_break  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      rx_meta    <= uart_rx;
      rxs        <= rx_meta;
      rxs_d      <= rxs;
      push_req   <= 1'b0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
      err_break  <= 1'b0;
      overflow   <= push_req && fifo_full && !pop;

      if (state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP}) begin
        bc <= bit_end ? '0 : bc + 16'd1;
        if (bc == half - 16'd1) s0 <= rxs;
        if (bc == half)         s1 <= rxs;
        if (bc == half + 16'd1) s2 <= rxs;
      end

      // Idle timer only runs while a partial beat is waiting in IDLE.
      if (state == ST_IDLE && ptr != '0 && !start_edge) begin
        if (idle_cnt == idle_lim - TW'(1)) begin
          idle_cnt  <= '0;
          push_req  <= 1'b1;
          push_data <= {1'b1, part_keep, lane_buf};
          ptr       <= '0;
          lane_buf  <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        idle_cnt <= '0;
      end

      case (state)
        ST_IDLE: begin
          if (start_edge) begin
            state <= ST_START;
            div_q <= baud_div;
            bc    <= '0;
          end
        end
        ST_START: begin
          if (bit_end) begin
            if (maj) begin
              state <= ST_IDLE;
            end else begin
              state    <= ST_DATA;
              bit_idx  <= '0;
              par_bit  <= 1'b0;
              par_err  <= 1'b0;
              stop_bad <= 1'b0;
              stop_idx <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            shreg <= {maj, shreg[DATA_BITS-1:1]};
            if (bit_idx == CW'(DATA_BITS - 1)) begin
              state <= (PARITY_MODE == PAR_NONE) ? ST_STOP : ST_PARITY;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            par_bit <= maj;
            par_err <= ((^shreg) ^ maj) != (PARITY_MODE == PAR_ODD);
            state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (STOP_BITS == 2 && !stop_idx) begin
              stop_bad <= stop_zero;
              stop_idx <= 1'b1;
            end else if (stop_zero || par_err) begin
              err_break  <= is_break;
              err_frame  <= stop_zero && !is_break;
              err_parity <= !stop_zero;
              ptr        <= '0;
              lane_buf   <= '0;
              bc         <= '0;
              state      <= ST_RECOVER;
            end else begin
              state <= ST_IDLE;
              if (ptr == PW'(LANES - 1)) begin
                push_req  <= 1'b1;
                push_data <= {1'b0, {LANES{1'b1}}, lane_ins};
                ptr       <= '0;
                lane_buf  <= '0;
              end else begin
                lane_buf <= lane_ins;
                ptr      <= ptr + 1'b1;
              end
            end
          end
        end
        ST_RECOVER: begin
          // Need one uninterrupted bit time of high line before re-arming.
          if (!rxs) begin
            bc <= '0;
          end else if (bit_end) begin
            bc    <= '0;
            state <= ST_IDLE;
          end else begin
            bc <= bc + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign pop = m_axis_tvalid & m_axis_tready;

  uart_rx_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .aclk   (aclk),
    .areset (areset),
    .push   (push_req),
    .din    (push_data),
    .pop    (pop),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_dout[BW-1:0];
  assign m_axis_tkeep  = fifo_dout[BW +: LANES];
  assign m_axis_tlast  = fifo_dout[FW-1];

endmodule
